// File: rtl/tests_stall_scheduler.sv
// Stall injection scheduler for verification environments.
// It holds one stall FSM per pipeline port. All ports share a seeded Galois LFSR,
// so a given seed always yields the same stall pattern. A run-length cap bounds
// how long any port is held in stall, which guarantees forward progress.
module tests_stall_scheduler #(
    parameter int unsigned N_PORT    = 2,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    parameter int unsigned MAX_RUN   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_PORT-1:0] req_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [1:0]        cfg_port_i,
    input  logic              cfg_enable_i,
    input  logic [7:0]        cfg_pct_i,
    input  logic [3:0]        cfg_burst_i,
    output logic [N_PORT-1:0] stall_o,
    output logic [31:0]       stall_total_o
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_COOL  = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    // A zero seed would lock the LFSR at zero, so it is promoted to 1.
    localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [5:0]  RC_MAX    = 6'(MAX_RUN);

    // ------------------------------------------------------------------
    // Config handshake: a write transfers on a rising clk edge when
    // cfg_valid_i && cfg_ready_o are both high. cfg_ready_o is low exactly
    // while the single pending slot is occupied. The master holds its fields
    // stable while valid is high and not yet accepted.
    // ------------------------------------------------------------------
    logic       pend_valid_q;
    logic [1:0] pend_port_q;
    logic       pend_en_q;
    logic [7:0] pend_pct_q;
    logic [3:0] pend_burst_q;
    logic       pend_busy;
    logic       pend_clear;
    logic [7:0] cfg_pct_clamped;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    logic [31:0] total_q;
    logic [32:0] total_sum;
    logic [31:0] total_d;
    logic [2:0]  stall_cnt;

    assign cfg_ready_o     = !pend_valid_q;
    assign cfg_pct_clamped = (cfg_pct_i > 8'd128) ? 8'd128 : cfg_pct_i;

    // The pending write stays while its target port is mid-burst; an out-of-range
    // index never matches a port, so that write simply drains.
    always_comb begin
        pend_busy = 1'b0;
        for (int p = 0; p < int'(N_PORT); p++) begin
            if ((pend_port_q == 2'(p)) && stall_o[p]) begin
                pend_busy = 1'b1;
            end
        end
    end

    assign pend_clear = pend_valid_q && !pend_busy;

    // Capture an accepted write into the pending slot; drop it once applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_port_q  <= 2'd0;
            pend_en_q    <= 1'b0;
            pend_pct_q   <= 8'd0;
            pend_burst_q <= 4'd0;
        end else if (cfg_valid_i && cfg_ready_o) begin
            pend_valid_q <= 1'b1;
            pend_port_q  <= cfg_port_i;
            pend_en_q    <= cfg_enable_i;
            pend_pct_q   <= cfg_pct_clamped;
            pend_burst_q <= cfg_burst_i;
        end else if (pend_clear) begin
            pend_valid_q <= 1'b0;
        end
    end

    // Galois LFSR step for x^32+x^22+x^2+x+1.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_MASK;
        end
    end

    // The LFSR advances every cycle regardless of port activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-port stall FSM
    // ------------------------------------------------------------------
    for (genvar p = 0; p < int'(N_PORT); p++) begin : g_port
        state_e     state_q;
        logic       stall_q;
        logic [4:0] bc_q;
        logic [5:0] rc_q;
        logic [7:0] pct_q;
        logic [3:0] burst_q;
        logic [6:0] draw;
        logic       hit;
        logic       apply;

        // Each port reads its own 7-bit slice, so draws are uniform in 0..127.
        assign draw  = lfsr_q[7*p +: 7];
        assign hit   = req_i[p] && ({1'b0, draw} < pct_q);
        assign apply = pend_valid_q && (pend_port_q == 2'(p)) && (state_q != S_STALL);

        // State step. A draw taken in the apply cycle still uses the old pct/burst.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_OFF;
                stall_q <= 1'b0;
                bc_q    <= 5'd0;
                rc_q    <= 6'd0;
                pct_q   <= 8'd0;
                burst_q <= 4'd0;
            end else begin
                unique case (state_q)
                    S_OFF: begin
                        if (apply && pend_en_q) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (apply && !pend_en_q) begin
                            state_q <= S_OFF;
                        end else if (hit) begin
                            state_q <= S_STALL;
                            stall_q <= 1'b1;
                            bc_q    <= {1'b0, burst_q};
                            rc_q    <= 6'd1;
                        end
                    end
                    S_STALL: begin
                        // The run cap wins over the burst counter and cuts a long burst short.
                        if (rc_q == RC_MAX) begin
                            state_q <= S_COOL;
                            stall_q <= 1'b0;
                        end else if (bc_q == 5'd0) begin
                            state_q <= S_RUN;
                            stall_q <= 1'b0;
                        end else begin
                            bc_q <= bc_q - 5'd1;
                            rc_q <= rc_q + 6'd1;
                        end
                    end
                    S_COOL: begin
                        state_q <= (apply && !pend_en_q) ? S_OFF : S_RUN;
                    end
                    default: begin
                        state_q <= S_OFF;
                        stall_q <= 1'b0;
                    end
                endcase
                if (apply) begin
                    pct_q   <= pend_pct_q;
                    burst_q <= pend_burst_q;
                end
            end
        end

        assign stall_o[p] = stall_q;
    end

    // ------------------------------------------------------------------
    // Saturating stall statistics
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt = 3'd0;
        for (int p = 0; p < int'(N_PORT); p++) begin
            stall_cnt = stall_cnt + {2'b00, stall_o[p]};
        end
    end

    assign total_sum = {1'b0, total_q} + {30'd0, stall_cnt};
    assign total_d   = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];

    // Accumulate stalled (port, cycle) pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= 32'd0;
        end else begin
            total_q <= total_d;
        end
    end

    assign stall_total_o = total_q;

endmodule
